// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared op and transfer-state encodings for register_file_banked.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [1:0] {
        REG_NOP   = 2'd0,
        REG_WRITE = 2'd1,
        REG_INC   = 2'd2,
        REG_DEC   = 2'd3
    } regfile_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } xfer_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_serial_xfer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_serial_xfer
// Description : Serial bank dump/load sequencer; the parent owns the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_serial_xfer
    import regfile_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  BANK_DEPTH = 16,
    localparam int IDX_W      = $clog2(BANK_DEPTH),
    localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_load,
    input  logic                  i_ser_in,
    output logic                  o_busy,
    output logic                  o_ser_valid,
    output logic                  o_done,
    output logic                  o_dump,
    output logic [IDX_W-1:0]      o_word_idx,
    output logic [BIT_W-1:0]      o_bit_idx,
    output logic                  o_bank_we,
    output logic [DATA_WIDTH-1:0] o_bank_wdata
);

    localparam logic [BIT_W-1:0] c_BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] c_WORD_LAST = IDX_W'(BANK_DEPTH - 1);

    xfer_state_e           r_state;
    xfer_state_e           w_state_nxt;
    logic [BIT_W-1:0]      r_bit;
    logic [IDX_W-1:0]      r_word;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_bit_last;
    logic                  w_active;

    assign w_bit_last  = (r_bit == c_BIT_LAST);
    assign w_active    = (r_state == DUMP) || (r_state == LOAD);
    // LSB arrives first, so each new bit enters at the top and walks down.
    assign w_shift_nxt = {i_ser_in, r_shift[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_word  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_active) begin
                r_bit <= w_bit_last ? '0 : r_bit + 1'b1;
                if (w_bit_last) begin
                    r_word <= r_word + 1'b1;
                end
            end else begin
                r_bit  <= '0;
                r_word <= '0;
            end
            if (r_state == LOAD) begin
                r_shift <= w_shift_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b1;
        o_ser_valid  = 1'b0;
        o_done       = 1'b0;
        o_dump       = 1'b0;
        o_bank_we    = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = i_load ? LOAD : DUMP;
                end
            end
            DUMP: begin
                o_ser_valid = 1'b1;
                o_dump      = 1'b1;
                if (w_bit_last && (r_word == c_WORD_LAST)) begin
                    w_state_nxt = DONE;
                end
            end
            LOAD: begin
                o_ser_valid = 1'b1;
                o_bank_we   = w_bit_last;
                if (w_bit_last && (r_word == c_WORD_LAST)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_word_idx   = r_word;
    assign o_bit_idx    = r_bit;
    assign o_bank_wdata = w_shift_nxt;

endmodule
`default_nettype wire

// File: rtl/register_file_banked.sv
`default_nettype none
// ============================================================================
// Module      : register_file_banked
// Description : GPR file with indirect bank, INC/DEC, post-increment pointers
//               and serial bank dump/load. REGFILE_BYPASS_EN enables
//               write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_banked
    import regfile_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_REGS   = 4,
    parameter int  BANK_DEPTH = 16,
    localparam int SEL_W      = $clog2(NUM_REGS),
    localparam int IDX_W      = $clog2(BANK_DEPTH),
    localparam int XFER_BITS  = BANK_DEPTH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  regfile_op_e           i_op,
    input  logic [SEL_W-1:0]      i_wr_sel,
    input  logic                  i_wr_indirect,
    input  logic                  i_post_inc,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [SEL_W-1:0]      i_rd1_sel,
    input  logic [SEL_W-1:0]      i_rd2_sel,
    input  logic                  i_rd1_indirect,
    output logic [DATA_WIDTH-1:0] o_rd1_data,
    output logic [DATA_WIDTH-1:0] o_rd2_data,
    output logic [DATA_WIDTH-1:0] o_ptr_out,
    output logic [XFER_BITS-1:0]  o_bank_flat,
    input  logic                  i_xfer_start,
    input  logic                  i_xfer_load,
    input  logic                  i_ser_in,
    output logic                  o_ser_out,
    output logic                  o_ser_valid,
    output logic                  o_busy,
    output logic                  o_xfer_done,
    output logic                  o_op_dropped
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_gpr  [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_bank [BANK_DEPTH];
    logic                  r_op_dropped;

    logic                  w_dump;
    logic                  w_bank_we;
    logic [IDX_W-1:0]      w_xfer_word;
    logic [BIT_W-1:0]      w_xfer_bit;
    logic [DATA_WIDTH-1:0] w_xfer_wdata;

    logic                  w_accept;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd1_idx;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_result;
    logic [DATA_WIDTH-1:0] w_ptr_inc;

    regfile_serial_xfer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BANK_DEPTH (BANK_DEPTH)
    ) u_xfer (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_xfer_start),
        .i_load       (i_xfer_load),
        .i_ser_in     (i_ser_in),
        .o_busy       (o_busy),
        .o_ser_valid  (o_ser_valid),
        .o_done       (o_xfer_done),
        .o_dump       (w_dump),
        .o_word_idx   (w_xfer_word),
        .o_bit_idx    (w_xfer_bit),
        .o_bank_we    (w_bank_we),
        .o_bank_wdata (w_xfer_wdata)
    );

    assign w_accept  = (i_op != REG_NOP) && !o_busy;
    assign w_wr_idx  = r_gpr[i_wr_sel][IDX_W-1:0];
    assign w_rd1_idx = r_gpr[i_rd1_sel][IDX_W-1:0];
    assign w_wr_old  = i_wr_indirect ? r_bank[w_wr_idx] : r_gpr[i_wr_sel];
    assign w_ptr_inc = r_gpr[i_wr_sel] + 1'b1;

    always_comb begin
        w_wr_result = w_wr_old;
        case (i_op)
            REG_WRITE: w_wr_result = i_wr_data;
            REG_INC:   w_wr_result = w_wr_old + 1'b1;
            REG_DEC:   w_wr_result = w_wr_old - 1'b1;
            default:   w_wr_result = w_wr_old;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_accept) begin
            if (!i_wr_indirect) begin
                r_gpr[i_wr_sel] <= w_wr_result;
            end else if (i_post_inc) begin
                r_gpr[i_wr_sel] <= w_ptr_inc;
            end
        end
    end

    // Ops and the load engine never collide: ops are only accepted while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_accept && i_wr_indirect) begin
            r_bank[w_wr_idx] <= w_wr_result;
        end else if (w_bank_we) begin
            r_bank[w_xfer_word] <= w_xfer_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_dropped <= 1'b0;
        end else begin
            r_op_dropped <= (i_op != REG_NOP) && o_busy;
        end
    end

    always_comb begin
        o_rd1_data = i_rd1_indirect ? r_bank[w_rd1_idx] : r_gpr[i_rd1_sel];
        o_rd2_data = r_gpr[i_rd2_sel];
`ifdef REGFILE_BYPASS_EN
        if (w_accept) begin
            if (i_wr_indirect) begin
                if (i_rd1_indirect && (w_rd1_idx == w_wr_idx)) begin
                    o_rd1_data = w_wr_result;
                end
                if (i_post_inc) begin
                    if (!i_rd1_indirect && (i_rd1_sel == i_wr_sel)) begin
                        o_rd1_data = w_ptr_inc;
                    end
                    if (i_rd2_sel == i_wr_sel) begin
                        o_rd2_data = w_ptr_inc;
                    end
                end
            end else begin
                if (!i_rd1_indirect && (i_rd1_sel == i_wr_sel)) begin
                    o_rd1_data = w_wr_result;
                end
                if (i_rd2_sel == i_wr_sel) begin
                    o_rd2_data = w_wr_result;
                end
            end
        end
`endif
    end

    assign o_ptr_out    = r_gpr[NUM_REGS-1];
    assign o_ser_out    = w_dump ? r_bank[w_xfer_word][w_xfer_bit] : 1'b0;
    assign o_op_dropped = r_op_dropped;

    for (genvar gi = 0; gi < BANK_DEPTH; gi++) begin : g_flat
        assign o_bank_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_bank[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_banked.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_banked
// Description : Scoreboard bench for register_file_banked (default 8/4/16 build).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_file_banked;
    import regfile_pkg::*;

    localparam int S_RD1 = 0, S_RD2 = 1, S_PTR = 2, S_FLAT = 3, S_BUSY = 4,
                   S_SVALID = 5, S_DROP = 6, S_DONE = 7, S_SER = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    regfile_op_e  op = REG_NOP;
    logic [1:0]   wr_sel = '0, rd1_sel = '0, rd2_sel = '0;
    logic         wr_indirect = 1'b0, post_inc = 1'b0, rd1_indirect = 1'b0;
    logic [7:0]   wr_data = '0;
    logic         xfer_start = 1'b0, xfer_load = 1'b0, ser_in = 1'b0;
    logic [7:0]   rd1_data, rd2_data, ptr_out;
    logic [127:0] bank_flat;
    logic         ser_out, ser_valid, busy, xfer_done, op_dropped;

    register_file_banked #(.DATA_WIDTH(8), .NUM_REGS(4), .BANK_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .i_op(op), .i_wr_sel(wr_sel), .i_wr_indirect(wr_indirect),
        .i_post_inc(post_inc), .i_wr_data(wr_data), .i_rd1_sel(rd1_sel), .i_rd2_sel(rd2_sel),
        .i_rd1_indirect(rd1_indirect), .o_rd1_data(rd1_data), .o_rd2_data(rd2_data),
        .o_ptr_out(ptr_out), .o_bank_flat(bank_flat), .i_xfer_start(xfer_start),
        .i_xfer_load(xfer_load), .i_ser_in(ser_in), .o_ser_out(ser_out),
        .o_ser_valid(ser_valid), .o_busy(busy), .o_xfer_done(xfer_done),
        .o_op_dropped(op_dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        int           sig;
        logic [127:0] val;
        string        name;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_bank [16];

    function automatic logic [127:0] probe(input int s);
        case (s)
            S_RD1:    return {120'd0, rd1_data};
            S_RD2:    return {120'd0, rd2_data};
            S_PTR:    return {120'd0, ptr_out};
            S_FLAT:   return bank_flat;
            S_BUSY:   return {127'd0, busy};
            S_SVALID: return {127'd0, ser_valid};
            S_DROP:   return {127'd0, op_dropped};
            S_DONE:   return {127'd0, xfer_done};
            default:  return {127'd0, ser_out};
        endcase
    endfunction

    function automatic logic [127:0] flat_of();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = exp_bank[i];
        return f;
    endfunction

    task automatic chk_at(input int c, input int s, input logic [127:0] v, input string n);
        exp_t e;
        e.cyc = c; e.sig = s; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic chk_now(input int s, input logic [127:0] v, input string n);
        chk_at(cyc, s, v, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t         e;
        logic [127:0] got;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            got = probe(e.sig);
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s @cyc %0d: got %0h want %0h", e.name, cyc, got, e.val);
            end
        end
    end

    task automatic set_op(input regfile_op_e o, input logic [1:0] s, input logic ind,
                          input logic pi, input logic [7:0] d);
        op = o; wr_sel = s; wr_indirect = ind; post_inc = pi; wr_data = d;
    endtask

    task automatic run_load(input int drop_at);
        xfer_start = 1'b1; xfer_load = 1'b1;
        step();
        xfer_start = 1'b0;
        for (int k = 0; k < 128; k++) begin
            ser_in = exp_bank[k/8][k%8];
            if (k == 0) begin
                chk_now(S_BUSY, 1, "load_busy");
                chk_now(S_SVALID, 1, "load_svalid");
            end
            if (drop_at >= 0) begin
                if (k == drop_at) set_op(REG_WRITE, 2'd1, 1'b0, 1'b0, 8'h99);
                else if (k == drop_at + 1) begin
                    set_op(REG_NOP, 2'd0, 1'b0, 1'b0, 8'h00);
                    chk_now(S_DROP, 1, "op_dropped_hi");
                end else if (k == drop_at + 2) chk_now(S_DROP, 0, "op_dropped_lo");
            end
            step();
        end
        ser_in = 1'b0;
        chk_now(S_DONE, 1, "load_done");
        chk_now(S_BUSY, 1, "load_done_busy");
        step();
        chk_now(S_DONE, 0, "load_done_pulse");
        chk_now(S_BUSY, 0, "load_busy_fall");
        chk_now(S_FLAT, flat_of(), "load_flat");
    endtask

    initial begin
        int   c;
        logic b;
        for (int i = 0; i < 16; i++) exp_bank[i] = '0;
        step(); step();
        chk_now(S_RD1, 0, "rst_rd1"); chk_now(S_RD2, 0, "rst_rd2");
        chk_now(S_PTR, 0, "rst_ptr"); chk_now(S_FLAT, 0, "rst_flat");
        chk_now(S_BUSY, 0, "rst_busy"); chk_now(S_SVALID, 0, "rst_svalid");
        total++;
        if (bank_flat !== 128'd0) begin
            bad++;
            $display("FAIL inline_rst_flat: got %0h", bank_flat);
        end
        step();
        rst = 1'b0;

        rd1_sel = 2'd1; rd2_sel = 2'd2;
        set_op(REG_WRITE, 2'd1, 1'b0, 1'b0, 8'hFF);
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD1, 8'hFF, "wr_gpr1_same");
`else
        chk_now(S_RD1, 8'h00, "wr_gpr1_same");
`endif
        step();
        set_op(REG_INC, 2'd1, 1'b0, 1'b0, 8'h55);
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD1, 8'h00, "inc_same");
`else
        chk_now(S_RD1, 8'hFF, "gpr1_ff");
`endif
        step();
        set_op(REG_DEC, 2'd2, 1'b0, 1'b0, 8'h00);
        chk_now(S_RD1, 8'h00, "inc_wrap");
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD2, 8'hFF, "dec_same");
`else
        chk_now(S_RD2, 8'h00, "gpr2_before_dec");
`endif
        step();
        set_op(REG_WRITE, 2'd0, 1'b0, 1'b0, 8'h13);
        chk_now(S_RD2, 8'hFF, "dec_wrap");
        total++;
        if (rd2_data !== 8'hFF) begin
            bad++;
            $display("FAIL inline_dec_wrap: got %0h", rd2_data);
        end
        step();
        rd1_sel = 2'd0;
        set_op(REG_WRITE, 2'd0, 1'b1, 1'b1, 8'hAA);
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD1, 8'h14, "postinc_fwd");
`else
        chk_now(S_RD1, 8'h13, "gpr0_13");
`endif
        step();
        set_op(REG_INC, 2'd3, 1'b0, 1'b1, 8'h00);
        chk_now(S_RD1, 8'h14, "postinc_ptr");
        chk_now(S_FLAT, 128'hAA00_0000, "ind_bank3");
        chk_now(S_PTR, 8'h00, "ptr_before");
        step();
        rd1_indirect = 1'b1; rd2_sel = 2'd0;
        set_op(REG_WRITE, 2'd0, 1'b1, 1'b0, 8'h5C);
        chk_now(S_PTR, 8'h01, "direct_postinc_ignored");
        chk_now(S_RD2, 8'h14, "gpr0_no_inc");
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD1, 8'h5C, "rd1_ind_fwd");
`else
        chk_now(S_RD1, 8'h00, "rd1_ind_bank4_old");
`endif
        step();
        set_op(REG_DEC, 2'd0, 1'b1, 1'b1, 8'h00);
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD1, 8'h5B, "ind_dec_fwd");
        chk_now(S_RD2, 8'h15, "ptr_inc_fwd");
`else
        chk_now(S_RD1, 8'h5C, "rd1_ind_bank4");
        chk_now(S_RD2, 8'h14, "gpr0_pre_dec");
`endif
        step();
        set_op(REG_NOP, 2'd0, 1'b0, 1'b0, 8'h00);
        rd1_indirect = 1'b0;
        chk_now(S_RD1, 8'h15, "gpr0_after_postinc");
        chk_now(S_FLAT, 128'h5B_AA00_0000, "ind_dec_bank4");
        step();

        for (int i = 0; i < 16; i++) exp_bank[i] = 8'(i * 8'h11);
        run_load(-1);
        step();

        xfer_start = 1'b1; xfer_load = 1'b0;
        set_op(REG_WRITE, 2'd0, 1'b1, 1'b0, 8'hC4);
        exp_bank[5] = 8'hC4;
        c = cyc;
        chk_at(c, S_SVALID, 0, "dump_idle_svalid");
        for (int k = 0; k < 128; k++) begin
            b = exp_bank[k/8][k%8];
            chk_at(c + 1 + k, S_SVALID, 1, "dump_valid");
            chk_at(c + 1 + k, S_SER, {127'd0, b}, "dump_bit");
        end
        chk_at(c + 129, S_DONE, 1, "dump_done");
        chk_at(c + 129, S_SVALID, 0, "dump_done_svalid");
        chk_at(c + 129, S_BUSY, 1, "dump_done_busy");
        chk_at(c + 130, S_BUSY, 0, "dump_busy_fall");
        chk_at(c + 130, S_DONE, 0, "dump_done_pulse");
        step();
        xfer_start = 1'b0;
        set_op(REG_NOP, 2'd0, 1'b0, 1'b0, 8'h00);
        repeat (129) step();

        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        repeat (9) step();
        chk_now(S_BUSY, 1, "pre_abort_busy");
        step();
        rst = 1'b1;
        chk_now(S_BUSY, 0, "abort_busy");
        chk_now(S_SVALID, 0, "abort_svalid");
        chk_now(S_SER, 0, "abort_ser");
        chk_now(S_FLAT, 0, "abort_flat");
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_now(S_DONE, 0, "abort_no_done");
            step();
        end

        set_op(REG_WRITE, 2'd1, 1'b0, 1'b0, 8'h31);
        step();
        set_op(REG_NOP, 2'd0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) exp_bank[i] = 8'h5A;
        run_load(5);
        rd1_sel = 2'd1;
        chk_now(S_RD1, 8'h31, "drop_gpr1_unchanged");
        #1;
        total++;
        if (rd1_data !== 8'h31) begin
            bad++;
            $display("FAIL inline_drop_gpr1: got %0h", rd1_data);
        end
        step();

        rd2_sel = 2'd2;
        set_op(REG_WRITE, 2'd2, 1'b0, 1'b0, 8'h77);
`ifdef REGFILE_BYPASS_EN
        chk_now(S_RD2, 8'h77, "byp_same");
`else
        chk_now(S_RD2, 8'h00, "byp_same_old");
`endif
        step();
        set_op(REG_NOP, 2'd0, 1'b0, 1'b0, 8'h00);
        chk_now(S_RD2, 8'h77, "byp_next");
        #1;
        total++;
        if (rd2_data !== 8'h77) begin
            bad++;
            $display("FAIL inline_byp_next: got %0h", rd2_data);
        end
        step(); step();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked, want %0h", e.name, e.val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
- Parametrised successor to the fixed 4-GPR register file used by the datapath.
- Provides NUM_REGS general-purpose registers and a BANK_DEPTH-entry indirect bank addressed through any GPR.
- Adds increment/decrement ops, post-increment pointer writes, and a serial bank dump/load engine with a busy handshake. The engine is used for debug and context save/restore.
- Sits between the control unit (op/selects) and the ALU (read ports).

Parameters:
- DATA_WIDTH, 8: width of every register and bank entry.
- NUM_REGS, 4: GPR count, power of two, minimum 2.
- BANK_DEPTH, 16: bank entries, power of two, at most 2**DATA_WIDTH.
- Derived localparams: SEL_W = $clog2(NUM_REGS); IDX_W = $clog2(BANK_DEPTH); XFER_BITS = BANK_DEPTH*DATA_WIDTH.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- op  in  regfile_op_e  REG_NOP / REG_WRITE / REG_INC / REG_DEC.
- wr_sel  in  SEL_W  target GPR, or pointer GPR when wr_indirect.
- wr_indirect  in  1  target is bank[gpr[wr_sel][IDX_W-1:0]].
- post_inc  in  1  with an indirect op, also increment pointer gpr[wr_sel].
- wr_data  in  DATA_WIDTH  write data.
- rd1_sel, rd2_sel  in  SEL_W  read selects.
- rd1_indirect  in  1  rd1 returns bank[gpr[rd1_sel][IDX_W-1:0]].
- rd1_data, rd2_data  out  DATA_WIDTH  combinational read data.
- ptr_out  out  DATA_WIDTH  gpr[NUM_REGS-1].
- bank_flat  out  DATA_WIDTH*BANK_DEPTH  entry i at [i*DATA_WIDTH +: DATA_WIDTH].
- xfer_start  in  1  start a transfer (sampled in IDLE only).
- xfer_load  in  1  direction: 0 = dump, 1 = load.
- ser_in  in  1  load bit stream.
- ser_out  out  1  dump bit stream.
- ser_valid  out  1  ser_out is valid / ser_in is being sampled this cycle.
- busy  out  1  transfer in progress.
- xfer_done  out  1  one-cycle pulse at the end of a transfer.
- op_dropped  out  1  registered pulse, high the cycle after an op was rejected.

Behaviour:
- Reset (async, active-high):
  - all GPRs, bank entries, FSM and counters cleared; FSM returns to IDLE.
  - every output 0.
  - Reset mid-transfer aborts the transfer; no xfer_done pulse is produced.
- Reads:
  - Combinational, with no bypass: a write becomes visible the cycle after its posedge.
  - Indirect index uses only the low IDX_W bits of the pointer.
- Ops execute at posedge when not busy:
  - REG_WRITE stores wr_data.
  - REG_INC / REG_DEC perform target ±1 modulo 2**DATA_WIDTH; wr_data is ignored. 0xFF+1 = 0x00 and 0x00-1 = 0xFF.
  - REG_NOP changes nothing.
  - post_inc, only when wr_indirect and op != REG_NOP: gpr[wr_sel] <= gpr[wr_sel]+1 (full width, wraps) in the same cycle as the bank update. The bank address uses the pre-increment value. post_inc with a direct op is ignored.
- Transfer FSM, states IDLE, DUMP, LOAD, DONE:
  - IDLE: on xfer_start, go to DUMP if xfer_load=0, else LOAD; bit counter = 0.
  - DUMP:
    - ser_valid=1; ser_out = bank[cnt/DATA_WIDTH][cnt%DATA_WIDTH], entry 0 first, LSB first.
    - Lasts XFER_BITS cycles, then DONE.
  - LOAD:
    - ser_valid=1; ser_in is shifted in LSB-first each cycle.
    - On the cycle carrying the last bit of an entry, the assembled word is written to that entry.
    - After XFER_BITS cycles, go to DONE.
  - DONE: xfer_done=1 for one cycle, then IDLE.
  - busy=1 in DUMP, LOAD and DONE.
  - ser_out=0 whenever the FSM is not in DUMP.
- Simultaneous events:
  - An op != REG_NOP while busy is rejected, and op_dropped pulses.
  - An op together with xfer_start in IDLE: the op executes and the transfer starts next cycle from post-op contents.
  - xfer_start while busy is ignored.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd1/rd2 forward this cycle's accepted write result when the read address matches the write target (direct GPR, or the same bank index when indirect).
  - A post_inc pointer increment is forwarded to direct reads of that GPR.
  - INC/DEC forward the computed value.
- Undefined: reads return stored state only.

Decomposition:
- Package regfile_pkg:
  - regfile_op_e (REG_NOP, REG_WRITE, REG_INC, REG_DEC, 2 bits).
  - xfer_state_e (IDLE, DUMP, LOAD, DONE).
- Sub-module regfile_serial_xfer:
  - Contains the FSM, bit counter and load shift register.
  - Outputs a word index, bit index and bank write-strobe/data to the parent.
- The parent owns all storage.

Test Plan (defaults):
- Reset then read: all rd/ptr/bank_flat = 0. Asserting reset mid-DUMP returns busy=0 and ser_valid=0 immediately, with no xfer_done.
- REG_WRITE gpr1=0xFF, then REG_INC gpr1 -> 0x00. REG_DEC gpr2 from 0 -> 0xFF.
- gpr0=0x13; indirect REG_WRITE 0xAA via gpr0 with post_inc -> bank[3]=0xAA, gpr0=0x14; rd1_indirect on gpr0 reads bank[4].
- Load bank[i]=i*0x11; dump -> 128 ser_valid cycles, first byte bits 0x00, byte 1 LSB-first = 1,0,0,0,1,0,0,0; xfer_done at cycle 129; busy falls after.
- LOAD streaming 0x5A×16 -> every bank_flat byte 0x5A. A REG_WRITE issued during LOAD -> op_dropped pulses and the GPR is unchanged.
- With REGFILE_BYPASS_EN: REG_WRITE gpr2=0x77 and rd2_sel=2 in the same cycle -> rd2_data=0x77 that cycle. Without the macro: the old value that cycle, 0x77 the next.
